alpha_reader: RTL and testbench
===============================

ALPHA_READER -- requirements
Module: alpha_reader

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 alpha_en  input  1  level; high = run a blend job, low = idle or abort.
REQ-005 src_base  input  16  source-image word base address, sampled at job start.
REQ-006 dst_base  input  16  destination-image word base address, sampled at job start.
REQ-007 num_pixels  input  16  pixel count, sampled at job start.
REQ-008 pixel_ready  input  1  consumer (blend controller) can accept a pixel this cycle.
REQ-009 mem_rdata  input  32  RGBA8888 read data.
REQ-010 mem_rvalid  input  1  one-cycle strobe; mem_rdata valid for the outstanding read.
REQ-011 mem_read  output  1  one-cycle read-request strobe.
REQ-012 mem_addr  output  16  word address for mem_read, held until mem_rvalid.
REQ-013 src_pixel  output  32  current source pixel.
REQ-014 dst_pixel  output  32  current destination pixel.
REQ-015 pixel_done  output  1  one-cycle strobe; pixel pair transferred to consumer.
REQ-016 read_done  output  1  level; every pixel of the job has been transferred.

Function
REQ-017 States SHALL be: IDLE, REQ_SRC, WAIT_SRC, REQ_DST, WAIT_DST, PRESENT, DONE.
REQ-018 IDLE with alpha_en=1:
- latch src_base, dst_base and num_pixels;
- clear the 16-bit index idx;
- go to DONE if num_pixels=0, else go to REQ_SRC.
REQ-019 REQ_SRC SHALL assert mem_read for one cycle with mem_addr=src_base+idx (mod 2^16), then go to WAIT_SRC.
REQ-020 WAIT_SRC SHALL hold mem_addr; on mem_rvalid it SHALL register mem_rdata into src_pixel and go to REQ_DST.
REQ-021 REQ_DST/WAIT_DST SHALL do the same as REQ-019/REQ-020 with dst_base+idx (mod 2^16) and dst_pixel, then go to PRESENT.
REQ-022 Memory latency from mem_read to mem_rvalid is one or more cycles, unbounded; only one read SHALL be outstanding at any time.
REQ-023 PRESENT with pixel_ready=0 SHALL hold src_pixel and dst_pixel stable and assert nothing.
REQ-024 PRESENT with pixel_ready=1 SHALL:
- assert pixel_done for exactly that cycle;
- increment idx;
- go to DONE if idx+1=num_pixels, else go to REQ_SRC.
REQ-025 Minimum time per pixel with single-cycle memory latency SHALL be 5 cycles (REQ_SRC to pixel_done inclusive).
REQ-026 DONE SHALL assert read_done continuously while alpha_en=1, and SHALL return to IDLE, clearing read_done, in the cycle after alpha_en=0.
REQ-027 alpha_en=0 in any state other than IDLE or DONE SHALL abort the job:
- go to IDLE next cycle;
- no pixel_done and no read_done;
- an in-flight mem_rvalid arriving in IDLE SHALL be ignored.
REQ-028 alpha_en=0 and pixel_ready=1 in the same PRESENT cycle SHALL abort with no pixel_done (abort has priority).
REQ-029 mem_rvalid outside WAIT_SRC/WAIT_DST SHALL be ignored.
REQ-030 Inputs src_base, dst_base and num_pixels changing during a job SHALL NOT affect that job.
REQ-031 num_pixels=0xFFFF SHALL transfer 65535 pixels, and address arithmetic SHALL wrap modulo 2^16 without error.
REQ-032 src_pixel and dst_pixel SHALL retain their last values in IDLE and DONE.

Reset
REQ-033 n_rst=0 SHALL immediately force state IDLE, with idx, all latched parameters, mem_read, mem_addr, src_pixel, dst_pixel, pixel_done and read_done cleared to 0, regardless of the current state.
REQ-034 After n_rst deasserts, the block SHALL start a job only on a clock edge with alpha_en=1.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- src_base=0x0100, dst_base=0x0200, num_pixels=3, memory latency 1, pixel_ready=1 -> reads 0x0100, 0x0200, 0x0101, 0x0201, 0x0102, 0x0202; 3 pixel_done pulses with the matching data; read_done high 1 cycle after the third pulse.
- num_pixels=0 -> no mem_read; read_done in cycle 2 after alpha_en rises; alpha_en low -> read_done low the next cycle.
- Latency 4 cycles and pixel_ready held low 10 cycles in PRESENT -> outputs stable, single pixel_done when pixel_ready rises.
- src_base=0xFFFF, num_pixels=2 -> source reads at 0xFFFF then 0x0000.
- alpha_en drop during WAIT_DST with late mem_rvalid -> IDLE, no pixel_done, no read_done, dst_pixel unchanged.
- n_rst asserted in PRESENT -> all outputs 0 asynchronously; a new job then runs correctly from idx 0.

Source files
------------

// File: rtl/alpha_reader_if.sv
// Signal bundle between the alpha-blend pixel reader, its job controller,
// the image memory and the blend consumer.
interface alpha_reader_if;
  logic        alpha_en;
  logic [15:0] src_base;
  logic [15:0] dst_base;
  logic [15:0] num_pixels;
  logic        pixel_ready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic [31:0] src_pixel;
  logic [31:0] dst_pixel;
  logic        pixel_done;
  logic        read_done;

  modport slave (
    input  alpha_en, src_base, dst_base, num_pixels, pixel_ready,
           mem_rdata, mem_rvalid,
    output mem_read, mem_addr, src_pixel, dst_pixel, pixel_done, read_done
  );

  modport master (
    output alpha_en, src_base, dst_base, num_pixels, pixel_ready,
           mem_rdata, mem_rvalid,
    input  mem_read, mem_addr, src_pixel, dst_pixel, pixel_done, read_done
  );
endinterface

// File: rtl/alpha_reader.sv
// Fetches source/destination RGBA pixel pairs one word at a time and hands
// each pair to the blend controller; one memory read outstanding at most.
module alpha_reader (
  input  logic          clk,
  input  logic          n_rst,
  alpha_reader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, REQ_SRC, WAIT_SRC, REQ_DST, WAIT_DST, PRESENT, DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_src_base;
  logic [15:0] r_dst_base;
  logic [15:0] r_num;
  logic [15:0] r_idx;
  logic [31:0] r_src_pix;
  logic [31:0] r_dst_pix;

  logic        w_latch;
  logic        w_cap_src;
  logic        w_cap_dst;
  logic        w_adv;
  logic        w_mem_read;
  logic        w_pixel_done;
  logic        w_read_done;
  logic [15:0] w_addr;
  logic [15:0] w_idx_inc;

  assign w_idx_inc = r_idx + 16'd1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Dropping alpha_en anywhere mid-job aborts before any other action.
  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_cap_src    = 1'b0;
    w_cap_dst    = 1'b0;
    w_adv        = 1'b0;
    w_mem_read   = 1'b0;
    w_pixel_done = 1'b0;
    w_read_done  = 1'b0;
    w_addr       = 16'd0;
    case (r_state)
      IDLE: begin
        if (bus.alpha_en) begin
          w_latch = 1'b1;
          w_next  = (bus.num_pixels == 16'd0) ? DONE : REQ_SRC;
        end
      end
      REQ_SRC: begin
        w_addr = r_src_base + r_idx;
        if (!bus.alpha_en) w_next = IDLE;
        else begin
          w_mem_read = 1'b1;
          w_next     = WAIT_SRC;
        end
      end
      WAIT_SRC: begin
        w_addr = r_src_base + r_idx;
        if (!bus.alpha_en) w_next = IDLE;
        else if (bus.mem_rvalid) begin
          w_cap_src = 1'b1;
          w_next    = REQ_DST;
        end
      end
      REQ_DST: begin
        w_addr = r_dst_base + r_idx;
        if (!bus.alpha_en) w_next = IDLE;
        else begin
          w_mem_read = 1'b1;
          w_next     = WAIT_DST;
        end
      end
      WAIT_DST: begin
        w_addr = r_dst_base + r_idx;
        if (!bus.alpha_en) w_next = IDLE;
        else if (bus.mem_rvalid) begin
          w_cap_dst = 1'b1;
          w_next    = PRESENT;
        end
      end
      PRESENT: begin
        if (!bus.alpha_en) w_next = IDLE;
        else if (bus.pixel_ready) begin
          w_pixel_done = 1'b1;
          w_adv        = 1'b1;
          w_next       = (w_idx_inc == r_num) ? DONE : REQ_SRC;
        end
      end
      DONE: begin
        w_read_done = 1'b1;
        if (!bus.alpha_en) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Job parameters are captured once so mid-job input changes are invisible.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_src_base <= 16'd0;
      r_dst_base <= 16'd0;
      r_num      <= 16'd0;
      r_idx      <= 16'd0;
    end else if (w_latch) begin
      r_src_base <= bus.src_base;
      r_dst_base <= bus.dst_base;
      r_num      <= bus.num_pixels;
      r_idx      <= 16'd0;
    end else if (w_adv) begin
      r_idx      <= w_idx_inc;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_src_pix <= 32'd0;
      r_dst_pix <= 32'd0;
    end else begin
      if (w_cap_src) r_src_pix <= bus.mem_rdata;
      if (w_cap_dst) r_dst_pix <= bus.mem_rdata;
    end
  end

  assign bus.mem_read   = w_mem_read;
  assign bus.mem_addr   = w_addr;
  assign bus.src_pixel  = r_src_pix;
  assign bus.dst_pixel  = r_dst_pix;
  assign bus.pixel_done = w_pixel_done;
  assign bus.read_done  = w_read_done;

endmodule

// File: tb/tb_alpha_reader.sv
// Directed bench for alpha_reader: behavioural memory with programmable
// latency, per-cycle logging at the falling edge, hand-computed expectations.
module tb_alpha_reader;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  alpha_reader_if bus();

  alpha_reader dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  int m_wait = 0;
  logic [15:0] m_addr = 16'd0;
  int rv_cnt = 0;
  int pd_cnt = 0;
  int rdone_cnt = 0;
  int rdone_first = -1;
  logic [15:0] rd_q[$];
  logic [31:0] pd_src_q[$];
  logic [31:0] pd_dst_q[$];
  int          pd_cyc_q[$];

  // Memory content: each word encodes its own address.
  function automatic logic [31:0] pix(input logic [15:0] a);
    return {~a, a};
  endfunction

  function automatic logic [31:0] rd_at(input int i);
    return (i < rd_q.size()) ? {16'h0, rd_q[i]} : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] pds_at(input int i);
    return (i < pd_src_q.size()) ? pd_src_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] pdd_at(input int i);
    return (i < pd_dst_q.size()) ? pd_dst_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rd_q.delete();
    pd_src_q.delete();
    pd_dst_q.delete();
    pd_cyc_q.delete();
    rv_cnt      = 0;
    pd_cnt      = 0;
    rdone_cnt   = 0;
    rdone_first = -1;
  endtask

  task automatic start_job(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    bus.src_base   = s;
    bus.dst_base   = d;
    bus.num_pixels = n;
    bus.alpha_en   = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int k = 0;
    while (!bus.read_done && k < maxc) begin
      tick();
      k++;
    end
    chk_eq(tag, {31'd0, bus.read_done}, 32'd1);
  endtask

  task automatic wait_rv(input string tag, input int target, input int maxc);
    int k = 0;
    while (rv_cnt < target && k < maxc) begin
      tick();
      k++;
    end
    chk_eq(tag, rv_cnt, target);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model and output logger, both on the falling edge.
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (!n_rst) m_wait = 0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = pix(m_addr);
          rv_cnt++;
        end
      end
      if (bus.mem_read) begin
        rd_q.push_back(bus.mem_addr);
        m_addr = bus.mem_addr;
        m_wait = lat;
      end
      if (bus.pixel_done) begin
        pd_cnt++;
        pd_src_q.push_back(bus.src_pixel);
        pd_dst_q.push_back(bus.dst_pixel);
        pd_cyc_q.push_back(cyc);
      end
      if (bus.read_done) begin
        rdone_cnt++;
        if (rdone_first < 0) rdone_first = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    logic [15:0] exp1 [6];
    exp1 = '{16'h0100, 16'h0200, 16'h0101, 16'h0201, 16'h0102, 16'h0202};

    n_rst           = 1'b0;
    bus.alpha_en    = 1'b0;
    bus.src_base    = 16'd0;
    bus.dst_base    = 16'd0;
    bus.num_pixels  = 16'd0;
    bus.pixel_ready = 1'b0;
    repeat (3) tick();
    chk_eq("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk_eq("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk_eq("rst_src_pixel", bus.src_pixel, 32'd0);
    chk_eq("rst_dst_pixel", bus.dst_pixel, 32'd0);
    chk_eq("rst_read_done", {31'd0, bus.read_done}, 32'd0);
    n_rst = 1'b1;
    repeat (3) tick();
    chk_eq("idle_no_reads", rd_q.size(), 0);

    // Three pixels, latency 1, consumer always ready; inputs scrambled mid-job.
    clear_log();
    lat = 1;
    bus.pixel_ready = 1'b1;
    start_job(16'h0100, 16'h0200, 16'd3);
    tick();
    bus.src_base   = 16'hAAAA;
    bus.dst_base   = 16'hBBBB;
    bus.num_pixels = 16'h0001;
    wait_done("s1_done", 100);
    bus.alpha_en = 1'b0;
    chk_eq("s1_rdone_hold", {31'd0, bus.read_done}, 32'd1);
    tick();
    chk_eq("s1_rdone_clr", {31'd0, bus.read_done}, 32'd0);
    chk_eq("s1_nreads", rd_q.size(), 6);
    for (int i = 0; i < 6; i++) chk_eq($sformatf("s1_addr%0d", i), rd_at(i), {16'h0, exp1[i]});
    chk_eq("s1_npd", pd_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("s1_src%0d", i), pds_at(i), pix(16'h0100 + 16'(i)));
      chk_eq($sformatf("s1_dst%0d", i), pdd_at(i), pix(16'h0200 + 16'(i)));
    end
    if (pd_cyc_q.size() >= 2) chk_eq("s1_pix_period", pd_cyc_q[1] - pd_cyc_q[0], 5);
    else chk_eq("s1_pix_period", pd_cyc_q.size(), 2);
    chk_eq("s1_rdone_lag", rdone_first - ((pd_cyc_q.size() > 0) ? pd_cyc_q[$] : 0), 1);
    tick();

    // Zero-length job.
    clear_log();
    start_job(16'h0300, 16'h0400, 16'd0);
    chk_eq("s2_rdone_c1", {31'd0, bus.read_done}, 32'd0);
    tick();
    chk_eq("s2_rdone_c2", {31'd0, bus.read_done}, 32'd1);
    repeat (2) tick();
    bus.alpha_en = 1'b0;
    tick();
    chk_eq("s2_rdone_clr", {31'd0, bus.read_done}, 32'd0);
    chk_eq("s2_no_reads", rd_q.size(), 0);
    tick();

    // Latency 4, consumer stalls 10 cycles in PRESENT.
    clear_log();
    lat = 4;
    bus.pixel_ready = 1'b0;
    start_job(16'h0010, 16'h0020, 16'd1);
    wait_rv("s3_reach_present", 2, 100);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.pixel_done || bus.mem_read || bus.read_done ||
          bus.src_pixel !== pix(16'h0010) || bus.dst_pixel !== pix(16'h0020)) bad++;
      tick();
    end
    chk_eq("s3_stall_bad_cycles", bad, 0);
    chk_eq("s3_src_held", bus.src_pixel, pix(16'h0010));
    bus.pixel_ready = 1'b1;
    @(negedge clk);
    chk_eq("s3_pd_on_ready", {31'd0, bus.pixel_done}, 32'd1);
    tick();
    chk_eq("s3_npd", pd_cnt, 1);
    chk_eq("s3_rdone", {31'd0, bus.read_done}, 32'd1);
    bus.alpha_en = 1'b0;
    repeat (2) tick();

    // Source address wrap.
    clear_log();
    lat = 1;
    start_job(16'hFFFF, 16'h1000, 16'd2);
    tick();
    wait_done("s4_done", 100);
    chk_eq("s4_addr0", rd_at(0), 32'h0000_FFFF);
    chk_eq("s4_addr2", rd_at(2), 32'h0000_0000);
    chk_eq("s4_addr3", rd_at(3), 32'h0000_1001);
    chk_eq("s4_src1", pds_at(1), pix(16'h0000));
    bus.alpha_en = 1'b0;
    repeat (2) tick();

    // Abort in WAIT_DST with the destination word arriving after the abort.
    clear_log();
    lat = 6;
    start_job(16'h0300, 16'h0400, 16'd2);
    bad = 0;
    while (rd_q.size() < 2 && bad < 100) begin
      tick();
      bad++;
    end
    chk_eq("s5_reach_wait_dst", rd_q.size(), 2);
    bus.alpha_en = 1'b0;
    repeat (10) tick();
    chk_eq("s5_late_rvalid_seen", rv_cnt, 2);
    chk_eq("s5_dst_unchanged", bus.dst_pixel, pix(16'h1001));
    chk_eq("s5_src_captured", bus.src_pixel, pix(16'h0300));
    chk_eq("s5_no_pd", pd_cnt, 0);
    chk_eq("s5_no_rdone", rdone_cnt, 0);
    chk_eq("s5_no_more_reads", rd_q.size(), 2);

    // Asynchronous reset while presenting, then a fresh job.
    clear_log();
    lat = 1;
    bus.pixel_ready = 1'b0;
    start_job(16'h0500, 16'h0600, 16'd2);
    wait_rv("s6_reach_present", 2, 100);
    bus.pixel_ready = 1'b1;
    n_rst = 1'b0;
    #1;
    chk_eq("s6_rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk_eq("s6_rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk_eq("s6_rst_src", bus.src_pixel, 32'd0);
    chk_eq("s6_rst_dst", bus.dst_pixel, 32'd0);
    chk_eq("s6_rst_pd", {31'd0, bus.pixel_done}, 32'd0);
    chk_eq("s6_rst_rdone", {31'd0, bus.read_done}, 32'd0);
    bus.alpha_en = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (2) tick();
    chk_eq("s6_no_pd_in_rst", pd_cnt, 0);
    clear_log();
    start_job(16'h0700, 16'h0800, 16'd2);
    tick();
    wait_done("s6_done", 100);
    chk_eq("s6_addr0", rd_at(0), 32'h0000_0700);
    chk_eq("s6_addr1", rd_at(1), 32'h0000_0800);
    chk_eq("s6_addr2", rd_at(2), 32'h0000_0701);
    chk_eq("s6_npd", pd_cnt, 2);
    chk_eq("s6_src0", pds_at(0), pix(16'h0700));
    chk_eq("s6_dst1", pdd_at(1), pix(16'h0801));
    bus.alpha_en = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
